// File: rtl/axi4_pkg.sv
// AXI4 master shared definitions.
// Burst/response encodings and FSM state codes.
package axi4_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW   = 3'd3;
   localparam logic [2:0] S_W    = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;

   // Any response other than OKAY counts as an error for the burst.
   function automatic logic resp_err(input logic [1:0] r);
      logic e;
      e = 1'b1;
      unique case (r)
         RESP_OKAY:   e = 1'b0;
         RESP_EXOKAY,
         RESP_SLVERR,
         RESP_DECERR: e = 1'b1;
         default:     e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 link signals between manager and subordinate.
// Master drives addresses/data/valids, slave drives readies/responses.
interface axi4_if #(
   parameter int ADDR_BITS    = 32,
   parameter int DATA_BITS    = 32,
   parameter int LOGSIZE_BITS = 3,
   parameter int LEN_BITS     = 8,
   parameter int BURST_BITS   = 2,
   parameter int RESP_BITS    = 2,
   parameter int WSTRB_BITS   = 4
);
   logic [ADDR_BITS-1:0]    araddr;
   logic                    arvalid;
   logic                    arready;
   logic [LOGSIZE_BITS-1:0] arsize;
   logic [LEN_BITS-1:0]     arlen;
   logic [BURST_BITS-1:0]   arburst;
   logic [DATA_BITS-1:0]    rdata;
   logic                    rvalid;
   logic                    rready;
   logic                    rlast;
   logic [RESP_BITS-1:0]    rresp;
   logic [ADDR_BITS-1:0]    awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [LOGSIZE_BITS-1:0] awsize;
   logic [LEN_BITS-1:0]     awlen;
   logic [BURST_BITS-1:0]   awburst;
   logic [DATA_BITS-1:0]    wdata;
   logic                    wvalid;
   logic                    wready;
   logic [WSTRB_BITS-1:0]   wstrb;
   logic                    wlast;
   logic                    bvalid;
   logic                    bready;
   logic [RESP_BITS-1:0]    bresp;

   modport master (
      output araddr, arvalid, arsize, arlen, arburst, rready,
      output awaddr, awvalid, awsize, awlen, awburst,
      output wdata, wvalid, wstrb, wlast, bready,
      input  arready, rdata, rvalid, rlast, rresp,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  araddr, arvalid, arsize, arlen, arburst, rready,
      input  awaddr, awvalid, awsize, awlen, awburst,
      input  wdata, wvalid, wstrb, wlast, bready,
      output arready, rdata, rvalid, rlast, rresp,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/axi4_beat_cnt.sv
// Burst beat counter shared by the R and W data paths.
// Holds at len on the final beat so len=all-ones never wraps.
module axi4_beat_cnt #(
   parameter int LEN_BITS = 8
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                clear,
   input  logic                inc,
   input  logic [LEN_BITS-1:0] len,
   output logic [LEN_BITS-1:0] cnt,
   output logic                last
);

   assign last = (cnt == len);

   // Count handshaked beats; compare before increment.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (inc && !last)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/axi4_master.sv
// AXI4 initiator: one command becomes one AR/R or AW/W/B burst.
// Single outstanding transaction; done pulses one cycle at the end.
module axi4_master
   import axi4_pkg::*;
#(
   parameter int ADDR_BITS    = 32,
   parameter int DATA_BITS    = 32,
   parameter int LOGSIZE_BITS = 3,
   parameter int LEN_BITS     = 8,
   parameter int BURST_BITS   = 2,
   parameter int RESP_BITS    = 2,
   parameter int WSTRB_BITS   = 4
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_BITS-1:0]    cmd_addr,
   input  logic [LEN_BITS-1:0]     cmd_len,
   input  logic [LOGSIZE_BITS-1:0] cmd_size,
   input  logic [BURST_BITS-1:0]   cmd_burst,
   input  logic                    wd_valid,
   output logic                    wd_ready,
   input  logic [DATA_BITS-1:0]    wd_data,
   input  logic [WSTRB_BITS-1:0]   wd_strb,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [DATA_BITS-1:0]    rd_data,
   output logic                    rd_last,
   output logic                    done,
   output logic                    err,
   axi4_if.master                  bus
);

   logic [2:0]              state;
   logic [2:0]              nxt;
   logic [ADDR_BITS-1:0]    addr_q;
   logic [LEN_BITS-1:0]     len_q;
   logic [LOGSIZE_BITS-1:0] size_q;
   logic [BURST_BITS-1:0]   burst_q;
   logic [LEN_BITS-1:0]     cnt;
   logic                    last;
   logic                    err_acc;
   logic                    accept;
   logic                    in_r;
   logic                    in_w;
   logic                    r_hs;
   logic                    w_hs;
   logic                    b_hs;
   logic                    fin;
   logic                    cur_err;
   logic                    unused_ok;

   assign unused_ok = &{1'b0, bus.rlast};

   assign cmd_ready = (state == S_IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign in_r      = (state == S_R);
   assign in_w      = (state == S_W);

   assign bus.arvalid = (state == S_AR);
   assign bus.araddr  = addr_q;
   assign bus.arlen   = len_q;
   assign bus.arsize  = size_q;
   assign bus.arburst = burst_q;
   assign bus.awvalid = (state == S_AW);
   assign bus.awaddr  = addr_q;
   assign bus.awlen   = len_q;
   assign bus.awsize  = size_q;
   assign bus.awburst = burst_q;

   assign bus.rready = in_r & rd_ready;
   assign rd_valid   = in_r & bus.rvalid;
   assign rd_data    = bus.rdata;
   assign rd_last    = in_r & last;

   assign bus.wvalid = in_w & wd_valid;
   assign wd_ready   = in_w & bus.wready;
   assign bus.wdata  = wd_data;
   assign bus.wstrb  = wd_strb;
   assign bus.wlast  = in_w & last;

   assign bus.bready = (state == S_B);

   assign r_hs    = bus.rvalid & bus.rready;
   assign w_hs    = bus.wvalid & bus.wready;
   assign b_hs    = bus.bvalid & bus.bready;
   assign fin     = (r_hs & last) | b_hs;
   assign cur_err = (r_hs & resp_err(bus.rresp))
                  | (b_hs & resp_err(bus.bresp));

   axi4_beat_cnt #(.LEN_BITS(LEN_BITS)) u_cnt (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .clear  (accept),
      .inc    (r_hs | w_hs),
      .len    (len_q),
      .cnt    (cnt),
      .last   (last)
   );

   // Next-state decode for the read and write burst sequences.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: if (cmd_valid) nxt = cmd_write ? S_AW : S_AR;
         S_AR:   if (bus.arready) nxt = S_R;
         S_R:    if (r_hs && last) nxt = S_IDLE;
         S_AW:   if (bus.awready) nxt = S_W;
         S_W:    if (w_hs && last) nxt = S_B;
         S_B:    if (bus.bvalid) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         state <= S_IDLE;
      else
         state <= nxt;
   end

   // Latch the command on accept; held until the burst ends.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
      end else if (accept) begin
         addr_q  <= cmd_addr;
         len_q   <= cmd_len;
         size_q  <= cmd_size;
         burst_q <= cmd_burst;
      end
   end

   // Accumulate non-OKAY responses across the burst.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         err_acc <= 1'b0;
      else if (accept)
         err_acc <= 1'b0;
      else if (r_hs || b_hs)
         err_acc <= err_acc | cur_err;
   end

   // One-cycle completion pulse with the burst error flag.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         done <= fin;
         err  <= fin & (err_acc | cur_err);
      end
   end

endmodule

// File: tb/tb_axi4_master.sv
// Directed bench for axi4_master with a scripted AXI4 slave.
// Inputs change at posedge+1, outputs are sampled at posedge+2.
module tb_axi4_master;
   import axi4_pkg::*;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic [2:0]  cmd_size = '0;
   logic [1:0]  cmd_burst = '0;
   logic        wd_valid = 1'b0;
   logic        wd_ready;
   logic [31:0] wd_data = '0;
   logic [3:0]  wd_strb = '0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [31:0] rd_data;
   logic        rd_last;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem  [0:255];
   logic [31:0] expd [0:255];

   axi4_if bus ();

   axi4_master dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_size  (cmd_size),
      .cmd_burst (cmd_burst),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready),
      .wd_data   (wd_data),
      .wd_strb   (wd_strb),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .done      (done),
      .err       (err),
      .bus       (bus)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [31:0] a,
                        input logic [7:0] l, input logic [1:0] b);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = l;
      cmd_size  = 3'd2;
      cmd_burst = b;
      #1 chk("cmd_ready_idle", cmd_ready, 1);
      cyc();
      cmd_valid = 1'b0;
      cmd_addr  = '1;
      cmd_len   = '1;
      cmd_size  = '0;
      cmd_burst = '1;
   endtask

   task automatic rd_burst(input logic [31:0] a, input logic [7:0] l,
                           input int ar_dly, input bit tog,
                           input int eb, input logic exp_err);
      int  beat;
      int  lasts;
      int  n;
      bit  hs;
      beat  = 0;
      lasts = 0;
      n     = 0;
      issue(1'b0, a, l, BURST_INCR);
      for (int i = 0; i <= ar_dly; i++) begin
         bus.arready = (i == ar_dly);
         #1;
         chk("arvalid", bus.arvalid, 1);
         chk("araddr", bus.araddr, a);
         chk("arlen", bus.arlen, l);
         chk("arsize", bus.arsize, 2);
         chk("arburst", bus.arburst, BURST_INCR);
         chk("done_ar", done, 0);
         cyc();
      end
      bus.arready = 1'b0;
      while (beat <= int'(l) && n < 4 * (int'(l) + 1) + 20) begin
         bus.rvalid = 1'b1;
         bus.rdata  = mem[beat];
         bus.rresp  = (beat == eb) ? RESP_SLVERR : RESP_OKAY;
         bus.rlast  = 1'b0;
         rd_ready   = tog ? (n[0] == 1'b0) : 1'b1;
         #1;
         hs = rd_valid & rd_ready;
         if (hs) begin
            chk("rd_data", rd_data, expd[beat]);
            chk("rd_last", rd_last, beat == int'(l));
            if (rd_last) lasts++;
         end
         chk("done_r", done, 0);
         cyc();
         if (hs) beat++;
         n++;
      end
      bus.rvalid = 1'b0;
      rd_ready   = 1'b0;
      chk("rd_beats", beat, int'(l) + 1);
      chk("rd_lasts", lasts, 1);
      chk("rd_done", done, 1);
      chk("rd_err", err, exp_err);
      chk("cmd_ready_done", cmd_ready, 1);
      cyc();
      chk("done_pulse", done, 0);
      chk("err_low", err, 0);
   endtask

   task automatic wr_burst(input logic [31:0] a, input logic [7:0] l,
                           input int aw_dly, input logic [1:0] br,
                           input logic exp_err);
      bus.wready = 1'b1;
      issue(1'b1, a, l, BURST_INCR);
      for (int i = 0; i <= aw_dly; i++) begin
         bus.awready = (i == aw_dly);
         wd_valid    = 1'b1;
         #1;
         chk("awvalid", bus.awvalid, 1);
         chk("awaddr", bus.awaddr, a);
         chk("awlen", bus.awlen, l);
         chk("wd_ready_aw", wd_ready, 0);
         chk("wvalid_aw", bus.wvalid, 0);
         cyc();
      end
      bus.awready = 1'b0;
      for (int i = 0; i <= int'(l); i++) begin
         wd_valid   = 1'b1;
         wd_data    = 32'(i + 1);
         wd_strb    = 4'hF;
         bus.bvalid = 1'b1;
         bus.bresp  = br;
         #1;
         chk("wvalid", bus.wvalid, 1);
         chk("wd_ready", wd_ready, 1);
         chk("wdata", bus.wdata, 32'(i + 1));
         chk("wstrb", bus.wstrb, 4'hF);
         chk("wlast", bus.wlast, i == int'(l));
         chk("bready_w", bus.bready, 0);
         mem[i] = bus.wdata;
         cyc();
      end
      wd_valid = 1'b0;
      #1;
      chk("bready_b", bus.bready, 1);
      chk("wd_ready_b", wd_ready, 0);
      chk("done_b", done, 0);
      cyc();
      bus.bvalid = 1'b0;
      chk("wr_done", done, 1);
      chk("wr_err", err, exp_err);
      chk("cmd_ready_wr", cmd_ready, 1);
      cyc();
      chk("wr_done_pulse", done, 0);
   endtask

   initial begin
      bus.arready = 1'b0;
      bus.rdata   = '0;
      bus.rvalid  = 1'b0;
      bus.rlast   = 1'b0;
      bus.rresp   = RESP_OKAY;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = RESP_OKAY;
      rd_ready    = 1'b1;
      cyc();
      cyc();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_arvalid", bus.arvalid, 0);
      chk("rst_awvalid", bus.awvalid, 0);
      chk("rst_wvalid", bus.wvalid, 0);
      chk("rst_wlast", bus.wlast, 0);
      chk("rst_bready", bus.bready, 0);
      chk("rst_rready", bus.rready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_araddr", bus.araddr, 0);
      rd_ready = 1'b0;
      PRESET   = 1'b0;
      cyc();

      mem[0]  = 32'hDEADBEEF;
      expd[0] = 32'hDEADBEEF;
      rd_burst(32'h1000_0000, 8'd0, 0, 1'b0, -1, 1'b0);

      wr_burst(32'h0000_2000, 8'd3, 0, RESP_OKAY, 1'b0);
      expd[0] = 32'd1;
      expd[1] = 32'd2;
      expd[2] = 32'd3;
      expd[3] = 32'd4;
      rd_burst(32'h0000_2000, 8'd3, 0, 1'b0, -1, 1'b0);

      mem[0]  = 32'h0000_00A0;
      mem[1]  = 32'h0000_00B1;
      mem[2]  = 32'h0000_00C2;
      mem[3]  = 32'h0000_00D3;
      expd[0] = 32'h0000_00A0;
      expd[1] = 32'h0000_00B1;
      expd[2] = 32'h0000_00C2;
      expd[3] = 32'h0000_00D3;
      rd_burst(32'h0000_3000, 8'd3, 5, 1'b1, -1, 1'b0);

      wr_burst(32'h0000_2000, 8'd3, 2, RESP_SLVERR, 1'b1);
      expd[0] = 32'd1;
      expd[1] = 32'd2;
      expd[2] = 32'd3;
      expd[3] = 32'd4;
      rd_burst(32'h0000_2000, 8'd3, 0, 1'b0, 1, 1'b1);
      rd_burst(32'h0000_2000, 8'd3, 1, 1'b0, -1, 1'b0);

      for (int i = 0; i < 256; i++) begin
         mem[i]  = 32'(i * 7 + 3);
         expd[i] = 32'(i * 7 + 3);
      end
      rd_burst(32'h0000_4000, 8'd255, 0, 1'b0, -1, 1'b0);

      bus.wready = 1'b1;
      issue(1'b1, 32'h0000_5000, 8'd3, BURST_INCR);
      bus.awready = 1'b1;
      cyc();
      bus.awready = 1'b0;
      wd_valid = 1'b1;
      wd_data  = 32'd11;
      #1 chk("rst_pre_wvalid", bus.wvalid, 1);
      cyc();
      wd_data = 32'd12;
      PRESET  = 1'b1;
      #1;
      chk("mid_wvalid", bus.wvalid, 0);
      chk("mid_wlast", bus.wlast, 0);
      chk("mid_awvalid", bus.awvalid, 0);
      chk("mid_arvalid", bus.arvalid, 0);
      chk("mid_bready", bus.bready, 0);
      chk("mid_wd_ready", wd_ready, 0);
      chk("mid_done", done, 0);
      chk("mid_cmd_ready", cmd_ready, 1);
      cyc();
      PRESET   = 1'b0;
      wd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_done", done, 0);
      end
      wr_burst(32'h0000_6000, 8'd1, 0, RESP_OKAY, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
